// File: rtl/if_fetch_if.sv
// if_fetch_if: byte-wide instruction read port between the fetch stage
// (master) and the memory controller (slave).
interface if_fetch_if;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ready_i;
    logic [7:0]  mem_data_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ready_i,
        input  mem_data_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ready_i,
        output mem_data_i
    );
endinterface

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage. Holds the PC, assembles each 32-bit
// instruction from four little-endian byte reads, and strobes get_inst
// once per instruction. Redirects on branch_flag_i and holds on stall[0].
// Optional direct-mapped instruction cache enabled by defining IF_ICACHE_EN.
module if_fetch #(
    parameter logic [31:0] RESET_PC       = 32'h0,
    parameter int          ICACHE_INDEX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    if_fetch_if.master  bus,
    output logic        get_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);
    typedef enum logic {
        S_FETCH = 1'b0,
        S_DONE  = 1'b1
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_pc;
    logic [31:0] r_inst;

    logic        w_hit;
    logic [31:0] w_hit_data;

    // Only stall[0] belongs to IF; target bits [1:0] are always replaced by 00.
    logic w_ports_unused;
    assign w_ports_unused = ^{stall[5:1], branch_target_i[1:0]};

`ifdef IF_ICACHE_EN
    localparam int LINES = 1 << ICACHE_INDEX_W;
    localparam int TAG_W = 30 - ICACHE_INDEX_W;

    logic [LINES-1:0]          r_valid;
    logic [TAG_W-1:0]          r_tag  [LINES];
    logic [31:0]               r_data [LINES];
    logic [ICACHE_INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]          w_tag;
    logic                      w_fill;

    assign w_idx      = r_pc[2 +: ICACHE_INDEX_W];
    assign w_tag      = r_pc[31 -: TAG_W];
    // Lookup only at the start of a word so a miss never switches mid-fetch.
    assign w_hit      = (r_state == S_FETCH) && (r_cnt == 2'd0) &&
                        r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_hit_data = r_data[w_idx];
    // Line is written as the last byte lands; a redirect in that cycle cancels it.
    assign w_fill     = !branch_flag_i && (r_state == S_FETCH) && !w_hit &&
                        bus.mem_ready_i && (r_cnt == 2'd3);

    // Valid bits are the only cache state that is cleared, and only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // Tag and data storage; the word is completed with the byte arriving now.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= {bus.mem_data_i, r_inst[23:0]};
        end
    end
`else
    logic [ICACHE_INDEX_W-1:0] w_idx_unused;
    assign w_idx_unused = r_pc[2 +: ICACHE_INDEX_W];
    assign w_hit        = 1'b0;
    assign w_hit_data   = '0;
`endif

    // Request is gated by reset so an abandoned fetch disappears immediately.
    assign bus.mem_req_o  = rst && (r_state == S_FETCH) && !w_hit;
    assign bus.mem_addr_o = {r_pc[31:2], r_cnt};
    assign get_inst       = rst && (r_state == S_DONE) && !stall[0] && !branch_flag_i;
    assign if_pc          = r_pc;
    assign if_inst        = r_inst;

    // Fetch FSM: redirect has priority over stall and over a completing byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
            r_cnt   <= 2'd0;
            r_pc    <= RESET_PC;
            r_inst  <= '0;
        end else if (branch_flag_i) begin
            r_state <= S_FETCH;
            r_cnt   <= 2'd0;
            r_pc    <= {branch_target_i[31:2], 2'b00};
            r_inst  <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (w_hit) begin
                        r_inst  <= w_hit_data;
                        r_state <= S_DONE;
                    end else if (bus.mem_ready_i) begin
                        r_inst[{r_cnt, 3'b000} +: 8] <= bus.mem_data_i;
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (!stall[0]) begin
                        r_pc    <= r_pc + 32'd4;
                        r_cnt   <= 2'd0;
                        r_state <= S_FETCH;
                    end
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed bench for if_fetch with a small word-table memory.
// Cache expectations follow IF_ICACHE_EN when the bench is built with it.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        get_inst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic [31:0] mem_word;

    int n_cmp = 0;
    int n_err = 0;

    if_fetch_if u_bus ();

    if_fetch #(
        .RESET_PC       (32'h0),
        .ICACHE_INDEX_W (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .bus             (u_bus),
        .get_inst        (get_inst),
        .if_pc           (if_pc),
        .if_inst         (if_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0010_0113;
            32'h0000_0008: return 32'h0020_81B3;
            32'h0000_000C: return 32'h4020_8233;
            32'h0000_0040: return 32'hFC1F_F06F;
            32'h0000_1000: return 32'hDEAD_BEEF;
            default:       return 32'h0000_0013;
        endcase
    endfunction

    // Little-endian byte memory built from the word table.
    always_comb begin
        mem_word = word_at({u_bus.mem_addr_o[31:2], 2'b00});
        u_bus.mem_data_i = mem_word[{u_bus.mem_addr_o[1:0], 3'b000} +: 8];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Four byte-request cycles then the DONE cycle; returns inside DONE.
    task automatic fetch_word(input logic [31:0] pc, input logic [31:0] inst, input bit hold);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("req", {31'd0, u_bus.mem_req_o}, 32'd1);
            chk("addr", u_bus.mem_addr_o, pc + k);
            chk("gi_fetch", {31'd0, get_inst}, 32'd0);
            if (k == 3 && hold) stall = 6'b000001;
            step();
        end
        #1;
        chk("gi_done", {31'd0, get_inst}, hold ? 32'd0 : 32'd1);
        chk("req_done", {31'd0, u_bus.mem_req_o}, 32'd0);
        chk("if_pc", if_pc, pc);
        chk("if_inst", if_inst, inst);
    endtask

    initial begin
        rst = 1'b0;
        stall = 6'd0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'd0;
        u_bus.mem_ready_i = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, u_bus.mem_req_o}, 32'd0);
        chk("rst_gi", {31'd0, get_inst}, 32'd0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_inst", if_inst, 32'h0);

        // First fetch after release
        rst = 1'b1;
        fetch_word(32'h0, 32'h0050_0093, 1'b0);
        step();

        // mem_ready_i low for three cycles on byte 2
        #1 chk("w_addr0", u_bus.mem_addr_o, 32'h4);
        step();
        #1 chk("w_addr1", u_bus.mem_addr_o, 32'h5);
        step();
        u_bus.mem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("w_hold_addr", u_bus.mem_addr_o, 32'h6);
            chk("w_hold_req", {31'd0, u_bus.mem_req_o}, 32'd1);
            chk("w_hold_gi", {31'd0, get_inst}, 32'd0);
            step();
        end
        u_bus.mem_ready_i = 1'b1;
        #1 chk("w_addr2", u_bus.mem_addr_o, 32'h6);
        step();
        #1 chk("w_addr3", u_bus.mem_addr_o, 32'h7);
        step();
        #1;
        chk("w_gi", {31'd0, get_inst}, 32'd1);
        chk("w_pc", if_pc, 32'h4);
        chk("w_inst", if_inst, 32'h0010_0113);
        step();

        // Stall held four cycles in DONE, stall raised during last byte
        fetch_word(32'h8, 32'h0020_81B3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            chk("st_gi", {31'd0, get_inst}, 32'd0);
            chk("st_pc", if_pc, 32'h8);
            chk("st_inst", if_inst, 32'h0020_81B3);
            chk("st_req", {31'd0, u_bus.mem_req_o}, 32'd0);
        end
        stall = 6'd0;
        #1 chk("st_release_gi", {31'd0, get_inst}, 32'd1);
        step();
        #1;
        chk("st_next_gi", {31'd0, get_inst}, 32'd0);
        chk("st_next_addr", u_bus.mem_addr_o, 32'hC);

        // Branch during byte 2 of pc 0xC
        step();
        #1 chk("br_addr1", u_bus.mem_addr_o, 32'hD);
        step();
        #1 chk("br_addr2", u_bus.mem_addr_o, 32'hE);
        branch_flag_i = 1'b1;
        branch_target_i = 32'h0000_1003;
        #1 chk("br_gi", {31'd0, get_inst}, 32'd0);
        step();
        branch_flag_i = 1'b0;
        branch_target_i = 32'd0;
        fetch_word(32'h1000, 32'hDEAD_BEEF, 1'b0);

        // Branch in DONE suppresses get_inst
        branch_flag_i = 1'b1;
        branch_target_i = 32'h40;
        #1 chk("br_done_gi", {31'd0, get_inst}, 32'd0);
        step();
        branch_flag_i = 1'b0;
        fetch_word(32'h40, 32'hFC1F_F06F, 1'b0);

        // Loop back to 0x40
        branch_flag_i = 1'b1;
        #1 chk("loop_br_gi", {31'd0, get_inst}, 32'd0);
        step();
        branch_flag_i = 1'b0;
        branch_target_i = 32'd0;
`ifdef IF_ICACHE_EN
        #1;
        chk("hit_req", {31'd0, u_bus.mem_req_o}, 32'd0);
        chk("hit_gi0", {31'd0, get_inst}, 32'd0);
        step();
        #1;
        chk("hit_gi1", {31'd0, get_inst}, 32'd1);
        chk("hit_req1", {31'd0, u_bus.mem_req_o}, 32'd0);
        chk("hit_pc", if_pc, 32'h40);
        chk("hit_inst", if_inst, 32'hFC1F_F06F);
`else
        fetch_word(32'h40, 32'hFC1F_F06F, 1'b0);
`endif
        step();
        #1 chk("loop_next_addr", u_bus.mem_addr_o, 32'h44);

        // Asynchronous reset during byte 1
        step();
        #1 rst = 1'b0;
        #1;
        chk("arst_req", {31'd0, u_bus.mem_req_o}, 32'd0);
        chk("arst_gi", {31'd0, get_inst}, 32'd0);
        chk("arst_pc", if_pc, 32'h0);
        chk("arst_inst", if_inst, 32'h0);
        step();
        #1 chk("arst_hold_req", {31'd0, u_bus.mem_req_o}, 32'd0);
        rst = 1'b1;
        fetch_word(32'h0, 32'h0050_0093, 1'b0);
        step();

        // PC wrap from 0xFFFFFFFC
        branch_flag_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFF;
        #1 chk("wrap_br_gi", {31'd0, get_inst}, 32'd0);
        step();
        branch_flag_i = 1'b0;
        branch_target_i = 32'd0;
        fetch_word(32'hFFFF_FFFC, 32'h0000_0013, 1'b0);
        step();
        #1;
        chk("wrap_pc", if_pc, 32'h0);
        chk("wrap_gi", {31'd0, get_inst}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the five-stage pipeline. Holds the PC, reads each 32-bit instruction from the byte-wide memory controller port as four little-endian byte reads, and presents it to the IF/ID register with a one-cycle `get_inst` strobe. It honours the pipeline stall vector and redirects on taken branches and jumps. An optional direct-mapped instruction cache serves repeated fetches without touching memory.

## Interface
Parameters:
- `RESET_PC`, 32'h0, PC value loaded at reset.
- `ICACHE_INDEX_W`, 6, log2 of cache lines (one word per line). Used only with `IF_ICACHE_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `stall`  in  6  pipeline stall vector; only `stall[0]` is used (1 = hold IF).
- `branch_flag_i`  in  1  redirect request from EX.
- `branch_target_i`  in  32  redirect PC; bits [1:0] are forced to 00.
- `mem_req_o`  out  1  byte read request to the memory controller.
- `mem_addr_o`  out  32  byte address of the current request.
- `mem_ready_i`  in  1  the controller has served the request this cycle.
- `mem_data_i`  in  8  read byte; valid when `mem_ready_i`=1.
- `get_inst`  out  1  one-cycle strobe: `if_pc`/`if_inst` hold a complete instruction.
- `if_pc`  out  32  PC of the presented instruction.
- `if_inst`  out  32  assembled instruction word.

## Operation
- States:
  - FETCH, with byte counter `cnt` 0..3.
  - DONE.
- FETCH:
  - `mem_req_o`=1 and `mem_addr_o`=`pc`+`cnt`.
  - When `mem_ready_i`=1, `mem_data_i` is written to `if_inst[8*cnt+7:8*cnt]` and `cnt` increments.
  - When `cnt`=3 and `mem_ready_i`=1, the state moves to DONE.
  - `stall[0]` does not pause byte reads.
- DONE:
  - `mem_req_o`=0 and `get_inst`=!`stall[0]` (combinational).
  - When `stall[0]`=0, on the next edge `pc` advances by 4, `cnt` clears to 0, and the state returns to FETCH.
  - When `stall[0]`=1, the block holds DONE with `if_pc`/`if_inst` stable.
- `if_pc` always equals `pc`.
- Branch: `branch_flag_i`=1 at an edge, in any state, sets `pc` to `{branch_target_i[31:2],2'b00}`, clears `cnt`, discards partial bytes, and enters FETCH.
  - Branch overrides stall and an in-flight byte completion.
  - `get_inst` is forced to 0 in any cycle with `branch_flag_i`=1.
- `mem_ready_i` is ignored while `mem_req_o`=0.
- Reset (`rst`=0, asynchronous):
  - `pc`=`RESET_PC`, state FETCH, `cnt`=0, `if_inst`=0.
  - `get_inst`=0, and `mem_req_o` is gated to 0 while reset is held.
  - A reset during a fetch abandons it.
- PC arithmetic is 32-bit modulo: 32'hFFFFFFFC + 4 wraps to 0. Byte addresses `pc`+`cnt` do not cross the word.

## Timing
- Uncached latency with `mem_ready_i` tied to 1:
  - 4 FETCH cycles, then 1 DONE cycle.
  - `get_inst` is asserted in cycle 5 after entry to FETCH.
  - Throughput is one instruction per 5 cycles.
- Each deasserted-`mem_ready_i` cycle adds one cycle. The address and request stay stable until served.
- Redirect: the first request to the target appears in the cycle after the edge that sampled `branch_flag_i`.
- `get_inst` is never high on two consecutive cycles for the same `pc`.

## Configuration
- `IF_ICACHE_EN` defined:
  - The block contains a direct-mapped cache of 2^`ICACHE_INDEX_W` words.
  - Each line holds a valid bit, tag = `pc[31:2+ICACHE_INDEX_W]`, and a data word.
  - Lookup happens in FETCH with `cnt`=0. On a hit, `mem_req_o`=0, the cached word loads `if_inst`, and the next state is DONE, giving 2 cycles per instruction.
  - On a miss, the normal byte fetch runs, and the line is written on entry to DONE.
  - All valid bits clear on reset only.
  - Branch during a miss: no line is written.
- `IF_ICACHE_EN` not defined: no cache storage, and every fetch goes to memory.

## Test plan
- Reset release, memory word at 0 = 32'h00500093, `mem_ready_i`=1:
  - addresses 0,1,2,3 requested on cycles 1-4;
  - `get_inst`=1 on cycle 5 with `if_pc`=0 and `if_inst`=32'h00500093;
  - the next request is at address 4.
- `mem_ready_i` low for 3 cycles on byte 2 → `mem_addr_o` holds `pc`+2 and `get_inst` is delayed by exactly 3 cycles.
- `stall[0]`=1 for 4 cycles in DONE → `get_inst` stays 0 and `if_pc`/`if_inst` are stable. On release, exactly one `get_inst` pulse occurs, then fetch resumes at `pc`+4.
- `branch_flag_i`=1 with target 32'h00001003 during byte 2:
  - partial bytes are discarded;
  - the next request is at 32'h00001000;
  - no `get_inst` for the old `pc`.
- `rst` asserted mid-fetch, asynchronously → `mem_req_o`=0 and `get_inst`=0 immediately. After release, fetch restarts at `RESET_PC`.
- `IF_ICACHE_EN`, loop branching back to 32'h40 → the second pass at 32'h40 has no `mem_req_o` and `get_inst` two cycles after redirect, with the same `if_inst`.
